// File: rtl/rl_queue_1r1w_pkg.sv
// Shared constants and helpers for the 1R1W first-word-fall-through queue.
package rl_queue_1r1w_pkg;

    localparam int unsigned OB_DEPTH = 2;

    function automatic int unsigned be_width(input int unsigned bits);
        return (bits + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/rl_ram_1r1w.sv
// One-read one-write RAM wrapper with a registered read port (1-cycle latency).
module rl_ram_1r1w
    import rl_queue_1r1w_pkg::*;
#(
    parameter int unsigned ABITS         = 4,
    parameter int unsigned DBITS         = 32,
    parameter string       TECHNOLOGY    = "GENERIC",
    parameter string       RW_CONTENTION = "DONT_CARE"
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         we_i,
    input  logic [ABITS-1:0]             waddr_i,
    input  logic [DBITS-1:0]             wdata_i,
    input  logic [be_width(DBITS)-1:0]   be_i,
    input  logic                         re_i,
    input  logic [ABITS-1:0]             raddr_i,
    output logic [DBITS-1:0]             rdata_o
);

    localparam int unsigned DEPTH = 2 ** ABITS;
    // Generic flop model holds read data between reads; macro models refresh every cycle.
    localparam bit HOLD_RDATA = (TECHNOLOGY == "GENERIC");

    logic [DBITS-1:0] mem_q [DEPTH];
    logic [DBITS-1:0] wmask;
    logic [DBITS-1:0] rdata_d;
    logic [DBITS-1:0] rdata_q;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < int'(DBITS); i++) begin
            wmask[i] = be_i[i / 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask) | (wdata_i & wmask);
        end
    end

    generate
        if (RW_CONTENTION == "WRITE_FIRST") begin : g_write_first
            always_comb begin
                rdata_d = mem_q[raddr_i];
                if (we_i && (waddr_i == raddr_i)) begin
                    rdata_d = (mem_q[raddr_i] & ~wmask) | (wdata_i & wmask);
                end
            end
        end else begin : g_read_old
            always_comb begin
                rdata_d = mem_q[raddr_i];
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i || !HOLD_RDATA) begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rl_queue_1r1w.sv
// FWFT valid/ready queue over a 1R1W RAM; a 2-entry output buffer hides the
// RAM read latency so the queue streams one word per cycle.
module rl_queue_1r1w
    import rl_queue_1r1w_pkg::*;
#(
    parameter int unsigned AW           = 4,
    parameter int unsigned DW           = 32,
    parameter int unsigned AFULL_THRESH = 2 ** AW,
    parameter string       TECHNOLOGY   = "GENERIC"
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            wr_valid_i,
    output logic            wr_ready_o,
    input  logic [DW-1:0]   wr_data_i,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,
    output logic [DW-1:0]   rd_data_o,
    output logic [AW+1:0]   count_o,
    output logic            almost_full_o
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CNT_W = AW + 2;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned BE_W  = be_width(DW);

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    ram_cnt;
    logic             rd_inflight_q, rd_inflight_d;
    logic [1:0]       ob_cnt_q, ob_cnt_d;
    logic             ob_head_q, ob_head_d;
    logic [DW-1:0]    ob_mem_q [OB_DEPTH];
    logic [DW-1:0]    ob_mem_d [OB_DEPTH];
    logic [DW-1:0]    rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_ready_q, wr_ready_d;
    logic             afull_q, afull_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push;
    logic             pop;
    logic             issue;
    logic [2:0]       occ;
    logic             ob_wr_idx;
    logic [DW-1:0]    ram_rdata;

    // Pointer/credit control, output buffer and status next-state.
    always_comb begin
        ram_cnt   = wptr_q - rptr_q;
        push      = wr_valid_i & wr_ready_q;
        pop       = rd_valid_q & rd_ready_i;
        occ       = 3'(ob_cnt_q) + 3'(rd_inflight_q) - 3'(pop);
        issue     = (ram_cnt != '0) && (occ < 3'd2);
        ob_wr_idx = ob_head_q ^ ob_cnt_q[0];

        wptr_d        = wptr_q + PW'(push);
        rptr_d        = rptr_q + PW'(issue);
        rd_inflight_d = issue;
        ob_mem_d      = ob_mem_q;
        if (rd_inflight_q) begin
            ob_mem_d[ob_wr_idx] = ram_rdata;
        end
        ob_head_d = ob_head_q ^ pop;
        ob_cnt_d  = ob_cnt_q + 2'(rd_inflight_q) - 2'(pop);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

        if (flush_i) begin
            wptr_d        = '0;
            rptr_d        = '0;
            rd_inflight_d = 1'b0;
            ob_cnt_d      = '0;
            ob_head_d     = 1'b0;
            count_d       = '0;
            ob_mem_d      = '{default: '0};
        end

        rd_valid_d = (ob_cnt_d != '0);
        rd_data_d  = ob_mem_d[ob_head_d];
        wr_ready_d = (PW'(wptr_d - rptr_d) != PW'(DEPTH));
        afull_d    = (32'(count_d) >= AFULL_THRESH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            rd_inflight_q <= 1'b0;
            ob_cnt_q      <= '0;
            ob_head_q     <= 1'b0;
            ob_mem_q      <= '{default: '0};
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            wr_ready_q    <= 1'b1;
            afull_q       <= 1'b0;
            count_q       <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            rd_inflight_q <= rd_inflight_d;
            ob_cnt_q      <= ob_cnt_d;
            ob_head_q     <= ob_head_d;
            ob_mem_q      <= ob_mem_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            wr_ready_q    <= wr_ready_d;
            afull_q       <= afull_d;
            count_q       <= count_d;
        end
    end

    // Reads only target written-but-unread slots, so read/write contention never matters.
    rl_ram_1r1w #(
        .ABITS        (AW),
        .DBITS        (DW),
        .TECHNOLOGY   (TECHNOLOGY),
        .RW_CONTENTION("DONT_CARE")
    ) u_ram (
        .clk_i  (clk_i),
        .rst_ni (~rst_i),
        .we_i   (push & ~flush_i),
        .waddr_i(wptr_q[AW-1:0]),
        .wdata_i(wr_data_i),
        .be_i   ({BE_W{1'b1}}),
        .re_i   (issue & ~flush_i),
        .raddr_i(rptr_q[AW-1:0]),
        .rdata_o(ram_rdata)
    );

    assign wr_ready_o    = wr_ready_q;
    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_data_q;
    assign count_o       = count_q;
    assign almost_full_o = afull_q;

endmodule

// File: tb/tb_rl_queue_1r1w.sv
// Self-checking bench for rl_queue_1r1w (AW=2, DW=8): queue-based reference model.
module tb_rl_queue_1r1w;

    localparam int unsigned AW  = 2;
    localparam int unsigned DW  = 8;
    localparam int          CAP = 6;
    localparam int          AFT = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          flush_i = 1'b0;
    logic          wr_valid_i = 1'b0;
    logic          wr_ready_o;
    logic [DW-1:0] wr_data_i = '0;
    logic          rd_valid_o;
    logic          rd_ready_i = 1'b0;
    logic [DW-1:0] rd_data_o;
    logic [AW+1:0] count_o;
    logic          almost_full_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference: words currently held, and the cycle each was pushed.
    logic [7:0] mq[$];
    int         mt[$];

    always #5 clk = ~clk;

    rl_queue_1r1w #(
        .AW          (AW),
        .DW          (DW),
        .AFULL_THRESH(AFT),
        .TECHNOLOGY  ("GENERIC")
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_data_i    (wr_data_i),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .rd_data_o    (rd_data_o),
        .count_o      (count_o),
        .almost_full_o(almost_full_o)
    );

    task automatic drive(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
        wr_valid_i = wv;
        wr_data_i  = wd;
        rd_ready_i = rr;
        flush_i    = fl;
    endtask

    // Advance one clock, updating the reference with this cycle's handshakes.
    task automatic tick();
        logic push;
        logic pop;
        push = (wr_valid_i === 1'b1) && (wr_ready_o === 1'b1);
        pop  = (rd_valid_o === 1'b1) && (rd_ready_i === 1'b1);
        if (rst_i || flush_i) begin
            mq.delete();
            mt.delete();
        end else begin
            if (pop && mq.size() > 0) begin
                void'(mq.pop_front());
                void'(mt.pop_front());
            end
            if (push) begin
                mq.push_back(wr_data_i);
                mt.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        tick();
        tick();
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid_o); end
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if (almost_full_o !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b expected 0", almost_full_o); end
        checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data_o); end
        rst_i = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready_o); end
        tick();
        checks++; if (count_o !== 4'd0 || rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_idle: count %0d valid %b expected 0/0", count_o, rd_valid_o); end
    endtask

    task automatic test_latency();
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        tick();
        checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL lat_count_n1: got %0d expected 1", count_o); end
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL lat_valid_n1: got %b expected 0", rd_valid_o); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL lat_valid_n2: got %b expected 0", rd_valid_o); end
        tick();
        checks++; if (rd_valid_o !== 1'b1 || rd_data_o !== 8'hA5) begin errors++; $display("FAIL lat_n3: valid %b data %0h expected 1/a5", rd_valid_o, rd_data_o); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        checks++; if (count_o !== 4'd0 || rd_valid_o !== 1'b0) begin errors++; $display("FAIL lat_after_pop: count %0d valid %b expected 0/0", count_o, rd_valid_o); end
    endtask

    task automatic test_fill();
        int   v;
        int   k;
        logic acc;
        v = 1;
        for (int c = 0; c < 20 && v <= 8; c++) begin
            drive(1'b1, 8'(v), 1'b0, 1'b0);
            acc = (wr_ready_o === 1'b1);
            tick();
            if (acc) v++;
        end
        checks++; if (v - 1 != CAP) begin errors++; $display("FAIL fill_accepted: got %0d expected %0d", v - 1, CAP); end
        checks++; if (wr_ready_o !== 1'b0) begin errors++; $display("FAIL fill_wr_ready: got %b expected 0", wr_ready_o); end
        checks++; if (count_o !== 4'd6) begin errors++; $display("FAIL fill_count: got %0d expected 6", count_o); end
        checks++; if (almost_full_o !== 1'b1) begin errors++; $display("FAIL fill_afull: got %b expected 1", almost_full_o); end
        k = 0;
        for (int c = 0; c < 30 && k < CAP; c++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            if (rd_valid_o === 1'b1) begin
                checks++; if (rd_data_o !== 8'(k + 1)) begin errors++; $display("FAIL fill_drain_data: got %0d expected %0d", rd_data_o, k + 1); end
                k++;
            end
            tick();
        end
        checks++; if (k != CAP || count_o !== 4'd0) begin errors++; $display("FAIL fill_drain_done: popped %0d count %0d expected 6/0", k, count_o); end
    endtask

    task automatic test_streaming();
        int i;
        int t;
        int nexp;
        i = 0;
        t = 0;
        nexp = 0;
        while (i < 100 && t < 150) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL stream_wr_ready: t %0d got %b expected 1", t, wr_ready_o); end
            if (rd_valid_o === 1'b1) begin
                checks++; if (rd_data_o !== 8'(nexp)) begin errors++; $display("FAIL stream_data: got %0d expected %0d", rd_data_o, nexp); end
                nexp++;
            end
            if (wr_ready_o === 1'b1) i++;
            tick();
            if (t >= 2) begin
                checks++; if (rd_valid_o !== 1'b1 || count_o !== 4'd3) begin errors++; $display("FAIL stream_steady: t %0d valid %b count %0d expected 1/3", t, rd_valid_o, count_o); end
            end
            t++;
        end
        for (int c = 0; c < 20 && mq.size() > 0; c++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            if (rd_valid_o === 1'b1) begin
                checks++; if (rd_data_o !== 8'(nexp)) begin errors++; $display("FAIL stream_drain_data: got %0d expected %0d", rd_data_o, nexp); end
                nexp++;
            end
            tick();
        end
        checks++; if (nexp != 100 || count_o !== 4'd0) begin errors++; $display("FAIL stream_total: popped %0d count %0d expected 100/0", nexp, count_o); end
    endtask

    task automatic test_back_to_back();
        logic pat [6];
        int   n_push;
        int   n_pop;
        int   j;
        logic wv;
        logic rr;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        n_push = 0;
        n_pop  = 0;
        j      = 0;
        while ((n_push < 200 || mq.size() > 0) && j < 2000) begin
            wv = (n_push < 200) && ($urandom_range(0, 3) != 0);
            rr = pat[j % 6];
            drive(wv, 8'($urandom), rr, 1'b0);
            if (mq.size() == 0) begin
                checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL bp_valid_empty: got %b expected 0", rd_valid_o); end
            end else if (mt[0] + 3 <= cyc) begin
                checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_live: got %b expected 1", rd_valid_o); end
            end
            if (rd_valid_o === 1'b1 && rr) begin
                checks++; if (mq.size() == 0 || rd_data_o !== mq[0]) begin errors++; $display("FAIL bp_data: got %0h expected %0h", rd_data_o, (mq.size() > 0) ? mq[0] : 8'h00); end
                n_pop++;
            end
            if (mq.size() < AFT) begin
                checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL bp_wr_ready_hi: size %0d got %b expected 1", mq.size(), wr_ready_o); end
            end else if (mq.size() == CAP) begin
                checks++; if (wr_ready_o !== 1'b0) begin errors++; $display("FAIL bp_wr_ready_lo: got %b expected 0", wr_ready_o); end
            end
            if (wv && wr_ready_o === 1'b1) n_push++;
            tick();
            checks++; if (count_o !== 4'(mq.size())) begin errors++; $display("FAIL bp_count: got %0d expected %0d", count_o, mq.size()); end
            checks++; if (almost_full_o !== (mq.size() >= AFT)) begin errors++; $display("FAIL bp_afull: got %b expected %b", almost_full_o, mq.size() >= AFT); end
            j++;
        end
        checks++; if (n_push != 200 || n_pop != 200) begin errors++; $display("FAIL bp_totals: pushed %0d popped %0d expected 200/200", n_push, n_pop); end
    endtask

    task automatic test_flush();
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        tick();
        checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", count_o); end
        drive(1'b1, 8'h77, 1'b1, 1'b1);
        tick();
        checks++; if (count_o !== 4'd0 || rd_valid_o !== 1'b0) begin errors++; $display("FAIL flush_clear: count %0d valid %b expected 0/0", count_o, rd_valid_o); end
        checks++; if (wr_ready_o !== 1'b1 || rd_data_o !== 8'h00) begin errors++; $display("FAIL flush_state: ready %b data %0h expected 1/0", wr_ready_o, rd_data_o); end
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        tick();
        checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL flush_new_count: got %0d expected 1", count_o); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL flush_new_n2: got %b expected 0", rd_valid_o); end
        tick();
        checks++; if (rd_valid_o !== 1'b1 || rd_data_o !== 8'h3C) begin errors++; $display("FAIL flush_new_n3: valid %b data %0h expected 1/3c", rd_valid_o, rd_data_o); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        checks++; if (rd_valid_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL flush_empty_after: valid %b count %0d expected 0/0", rd_valid_o, count_o); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_streaming();
        test_back_to_back();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
